// File: rtl/callret_seq_pkg.sv
// Shared encodings for the call/return command sequencer.
package callret_seq_pkg;

    // Decoder-level command opcodes
    localparam logic [1:0] OP_CALL = 2'd0;
    localparam logic [1:0] OP_RET  = 2'd1;
    localparam logic [1:0] OP_PUSH = 2'd2;
    localparam logic [1:0] OP_POP  = 2'd3;

    // Sticky fault codes
    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UNF  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH_RA,
        S_PUSH_FL,
        S_POP_FL,
        S_POP_RA,
        S_PUSH_D,
        S_POP_D,
        S_DONE,
        S_FAULT
    } state_t;

    // Everything a command needs after the accept cycle
    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  target;
        logic [31:0] data;
        logic [7:0]  ret_addr;
        logic [7:0]  flags;
    } cmd_t;

    // Return address wraps inside the 8-bit address space
    function automatic logic [7:0] calc_ret_addr(input logic [7:0] pc, input int unsigned step);
        return pc + step[7:0];
    endfunction

endpackage

// File: rtl/callret_seq_depth_tracker.sv
// Up/down occupancy counter mirroring the downstream stack pointer.
module depth_tracker #(
    parameter int DEPTH = 2050,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [DW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          near_full
);

    // Track pushes and pops; simultaneous inc/dec cancels out
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && !dec)
            count <= count + DW'(1);
        else if (dec && !inc)
            count <= count - DW'(1);
    end

    assign full      = (count == DW'(DEPTH));
    assign empty     = (count == '0);
    // Fewer than two free slots left: a two-word frame would not fit
    assign near_full = (count > DW'(DEPTH - 2));

endmodule

// File: rtl/callret_seq.sv
// Turns CALL/RET/PUSH/POP commands into ordered single-cycle stack strobes.
module callret_seq
    import callret_seq_pkg::*;
#(
    parameter int          DEPTH   = 2050,
    parameter int unsigned PC_STEP = 4,
    parameter int          DW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_target,
    input  logic [31:0]   cmd_data,
    input  logic [7:0]    pc,
    input  logic [7:0]    flags,
    output logic          stack_push,
    output logic          stack_pop,
    output logic [31:0]   stack_wdata,
    input  logic [7:0]    stack_rdata,
    output logic          pc_load,
    output logic [7:0]    pc_next,
    output logic          flags_load,
    output logic [7:0]    flags_next,
    output logic          pop_valid,
    output logic [7:0]    pop_data,
    output logic [DW-1:0] depth,
    output logic          fault,
    output logic [1:0]    fault_code,
    input  logic          fault_clr
);

    state_t     state, state_nxt;
    cmd_t       cmd_q;
    logic [1:0] code_q, code_nxt;
    logic [7:0] pc_q, flags_q;
    logic       full, empty, near_full;

    depth_tracker #(.DEPTH(DEPTH), .DW(DW)) u_depth (
        .clk       (clk),
        .rst       (rst),
        .inc       (stack_push),
        .dec       (stack_pop),
        .count     (depth),
        .full      (full),
        .empty     (empty),
        .near_full (near_full)
    );

    // State, fault code, latched command and restored PC/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            code_q  <= FLT_NONE;
            cmd_q   <= '0;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            state  <= state_nxt;
            code_q <= code_nxt;
            if (cmd_valid && cmd_ready) begin
                cmd_q.op       <= cmd_op;
                cmd_q.target   <= cmd_target;
                cmd_q.data     <= cmd_data;
                cmd_q.ret_addr <= calc_ret_addr(pc, PC_STEP);
                cmd_q.flags    <= flags;
            end
            if (state == S_POP_FL)
                flags_q <= stack_rdata;
            if (state == S_POP_RA)
                pc_q <= stack_rdata;
            if (state == S_DONE && cmd_q.op == OP_CALL)
                pc_q <= cmd_q.target;
        end
    end

    // Next state and per-state strobes; range checks happen at accept so the RAM is never touched on a fault
    always_comb begin
        state_nxt   = state;
        code_nxt    = code_q;
        cmd_ready   = 1'b0;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        stack_wdata = '0;
        pc_load     = 1'b0;
        flags_load  = 1'b0;
        pop_valid   = 1'b0;
        pop_data    = '0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CALL: begin
                            if (near_full) begin
                                state_nxt = S_FAULT;
                                code_nxt  = FLT_OVF;
                            end else begin
                                state_nxt = S_PUSH_RA;
                            end
                        end
                        OP_RET: begin
                            if (depth < DW'(2)) begin
                                state_nxt = S_FAULT;
                                code_nxt  = FLT_UNF;
                            end else begin
                                state_nxt = S_POP_FL;
                            end
                        end
                        OP_PUSH: begin
                            if (full) begin
                                state_nxt = S_FAULT;
                                code_nxt  = FLT_OVF;
                            end else begin
                                state_nxt = S_PUSH_D;
                            end
                        end
                        default: begin
                            if (empty) begin
                                state_nxt = S_FAULT;
                                code_nxt  = FLT_UNF;
                            end else begin
                                state_nxt = S_POP_D;
                            end
                        end
                    endcase
                end
            end
            S_PUSH_RA: begin
                stack_push  = 1'b1;
                stack_wdata = {24'h0, cmd_q.ret_addr};
                state_nxt   = S_PUSH_FL;
            end
            S_PUSH_FL: begin
                stack_push  = 1'b1;
                stack_wdata = {24'h0, cmd_q.flags};
                state_nxt   = S_DONE;
            end
            S_POP_FL: begin
                stack_pop = 1'b1;
                state_nxt = S_POP_RA;
            end
            S_POP_RA: begin
                stack_pop = 1'b1;
                state_nxt = S_DONE;
            end
            S_PUSH_D: begin
                stack_push  = 1'b1;
                stack_wdata = cmd_q.data;
                state_nxt   = S_IDLE;
            end
            S_POP_D: begin
                stack_pop = 1'b1;
                pop_valid = 1'b1;
                pop_data  = stack_rdata;
                state_nxt = S_IDLE;
            end
            S_DONE: begin
                pc_load    = 1'b1;
                flags_load = (cmd_q.op == OP_RET);
                state_nxt  = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_nxt = S_IDLE;
                    code_nxt  = FLT_NONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CALL presents its target in the DONE cycle; otherwise the held value shows
    assign pc_next    = (state == S_DONE && cmd_q.op == OP_CALL) ? cmd_q.target : pc_q;
    assign flags_next = flags_q;
    assign fault      = (state == S_FAULT);
    assign fault_code = code_q;

endmodule

// File: doc/callret_seq.md
Name: callret_seq

Overview:
- Command sequencer directly upstream of the 32-bit-word RAM stack block (PUSH/POP strobes, 32-bit write data, 8-bit read data).
- Turns decoder-level CALL/RET/PUSH/POP commands into correctly ordered single-cycle PUSH/POP strobes.
- Builds and tears down two-word call frames: return address, then flags.
- Mirrors stack depth so overflow/underflow are caught before the stack RAM is corrupted.

Parameters:
- DEPTH, 2050, capacity of the downstream stack in words.
- PC_STEP, 4, byte increment from the CALL instruction address to its return address.
- DW, 12, depth counter width; must hold DEPTH, i.e. >= clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer accepts a command this cycle.
- cmd_op  in  2  0=CALL, 1=RET, 2=PUSH, 3=POP.
- cmd_target  in  8  CALL destination address.
- cmd_data  in  32  PUSH payload.
- pc  in  8  address of the current instruction.
- flags  in  8  current flag byte.
- stack_push  out  1  to stack PUSH.
- stack_pop  out  1  to stack POP.
- stack_wdata  out  32  to stack Input.
- stack_rdata  in  8  from stack OUTPUT; valid combinationally in a POP cycle.
- pc_load  out  1  one-cycle strobe to load pc_next.
- pc_next  out  8  new program counter.
- flags_load  out  1  one-cycle strobe to load flags_next.
- flags_next  out  8  restored flags.
- pop_valid  out  1  pop_data valid this cycle.
- pop_data  out  8  popped byte for a POP command.
- depth  out  DW  current stack occupancy.
- fault  out  1  sticky fault.
- fault_code  out  2  1=overflow, 2=underflow, 0=none.
- fault_clr  in  1  clears a fault.

Behaviour:
- Reset, asynchronous: state=IDLE; depth=0; fault=0; fault_code=0; pc_next=0; flags_next=0; every strobe output 0. The stack shares rst, so both pointers restart together. Reset mid-command abandons the command.
- Handshake:
  - Command accepted on cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE with no fault.
  - pc, flags, cmd_target and cmd_data are latched at accept.
- States: IDLE, PUSH_RA, PUSH_FL, POP_FL, POP_RA, PUSH_D, POP_D, DONE, FAULT.
- CALL, accepted at cycle t:
  - If depth > DEPTH-2: go to FAULT with code 1. No strobes.
  - Otherwise:
    - t+1 PUSH_RA: stack_push=1, stack_wdata = zero-extended (pc+PC_STEP) mod 256.
    - t+2 PUSH_FL: stack_push=1, stack_wdata = zero-extended flags.
    - t+3 DONE: pc_load=1, pc_next=target.
    - t+4 IDLE.
- RET:
  - If depth < 2: go to FAULT with code 2.
  - Otherwise:
    - POP_FL: stack_pop=1; capture stack_rdata into flags_next.
    - POP_RA: stack_pop=1; capture stack_rdata into pc_next.
    - DONE: pc_load=1, flags_load=1.
    - Then IDLE.
- PUSH:
  - If depth == DEPTH: go to FAULT with code 1.
  - Otherwise PUSH_D: stack_push=1, stack_wdata=cmd_data. Then IDLE.
- POP:
  - If depth == 0: go to FAULT with code 2.
  - Otherwise POP_D: stack_pop=1, pop_valid=1, pop_data=stack_rdata in the same cycle. Then IDLE.
- depth: +1 on every stack_push cycle, -1 on every stack_pop cycle. stack_push and stack_pop are never high together.
- FAULT: fault=1 and fault_code hold; all strobes 0; depth unchanged. fault_clr high for one cycle → IDLE next cycle with fault=0 and code=0. fault_clr outside FAULT has no effect.
- pc_next and flags_next hold their values between loads.
- Arithmetic: return address wraps mod 256 (pc=0xFE, PC_STEP=4 → 0x02). Depth never wraps; the fault checks prevent it.

Decomposition:
- Shared package holds:
  - op encodings: OP_CALL, OP_RET, OP_PUSH, OP_POP.
  - fault codes: FLT_NONE, FLT_OVF, FLT_UNF.
  - the state enum.
- One natural sub-module, depth_tracker: an up/down counter with full/empty/near-full compares. It is reused for overflow checks elsewhere.

Test Plan:
- Reset, then CALL with pc=0x10, flags=0xA5, target=0x80 → pushes 0x14 then 0xA5 on consecutive cycles, pc_load with pc_next=0x80 at t+3, depth=2, cmd_ready back at t+4.
- RET following that CALL, with a behavioural stack model attached → pops yield flags_next=0xA5 and pc_next=0x14, pc_load and flags_load together at DONE, depth=0.
- RET with depth=0 → no strobes, fault=1, fault_code=2; fault_clr pulse → cmd_ready=1 next cycle, depth still 0.
- PUSH 0x33 ×2049, then CALL → overflow fault (depth=2049 > 2048), depth unchanged; a single PUSH after fault_clr succeeds and depth=2050.
- CALL with pc=0xFE → first pushed word is 0x00000002.
- Assert rst during PUSH_FL of a CALL → all outputs 0 immediately, depth=0, state IDLE after release.
